// File: rtl/sdram_word_arbiter.sv
// Two-port 32-bit word arbiter onto a 16-bit SDRAM controller port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   pN_req/we/addr/wdata  port N request (0 = loader, 1 = CPU)
//   pN_ack                one-cycle completion pulse for port N
//   rdata                 last completed read word
//   busy                  transaction in flight
//   az_*                  command side towards the SDRAM controller
//   za_*                  response side from the SDRAM controller
module sdram_word_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [20:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [20:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [21:0] az_addr,
  output logic [1:0]  az_be_n,
  output logic        az_cs,
  output logic [15:0] az_data,
  output logic        az_rd_n,
  output logic        az_wr_n,
  input  logic [15:0] za_data,
  input  logic        za_valid,
  input  logic        za_waitrequest
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    ISSUE_HI,
    WAIT_RD,
    DONE
  } state_t;

  state_t      state, state_n;
  logic        gnt, gnt_n;
  logic        we_q;
  logic [20:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  beats, beats_n;
  logic [15:0] rbuf_lo, rbuf_hi;
  logic        any_req;
  logic        issue;
  logic        take;

  assign any_req = p0_req | p1_req;
  assign issue   = (state == ISSUE_LO) | (state == ISSUE_HI);

  // Read beats count only once the low command is accepted and
  // only up to two per transaction; anything else is dropped.
  assign take = za_valid & ~we_q & (beats != 2'd2) &
                ((state == ISSUE_HI) | (state == WAIT_RD));
  assign beats_n = beats + {1'b0, take};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    gnt_n = ~p0_req;
    if (p0_req & p1_req)
      gnt_n = ~last_grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= 1'b1;
    else if (state == IDLE && any_req)
      last_grant <= gnt_n;
  end
`else
  always_comb begin
    gnt_n = ~p0_req;
  end
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (any_req)
          state_n = ISSUE_LO;
      ISSUE_LO:
        if (!za_waitrequest)
          state_n = ISSUE_HI;
      ISSUE_HI:
        if (!za_waitrequest) begin
          if (we_q || beats_n == 2'd2)
            state_n = DONE;
          else
            state_n = WAIT_RD;
        end
      WAIT_RD:
        if (beats_n == 2'd2)
          state_n = DONE;
      DONE:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  always_comb begin
    az_cs   = issue;
    az_be_n = 2'b00;
    az_rd_n = ~(issue & ~we_q);
    az_wr_n = ~(issue & we_q);
    az_addr = 22'd0;
    az_data = 16'd0;
    if (state == ISSUE_LO) begin
      az_addr = {addr_q, 1'b0};
      az_data = wdata_q[15:0];
    end else if (state == ISSUE_HI) begin
      az_addr = {addr_q, 1'b1};
      az_data = wdata_q[31:16];
    end
    busy   = (state != IDLE);
    p0_ack = (state == DONE) & ~gnt;
    p1_ack = (state == DONE) & gnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 21'd0;
      wdata_q <= 32'd0;
      beats   <= 2'd0;
      rbuf_lo <= 16'd0;
      rbuf_hi <= 16'd0;
      rdata   <= 32'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        gnt     <= gnt_n;
        we_q    <= gnt_n ? p1_we : p0_we;
        addr_q  <= gnt_n ? p1_addr : p0_addr;
        wdata_q <= gnt_n ? p1_wdata : p0_wdata;
        beats   <= 2'd0;
      end else if (take) begin
        beats <= beats_n;
        if (beats == 2'd0)
          rbuf_lo <= za_data;
        else
          rbuf_hi <= za_data;
      end
      // rdata only moves when a read finishes, so it stays stable
      // while the next read collects its beats.
      if (state_n == DONE && state != DONE && !we_q)
        rdata <= {take ? za_data : rbuf_hi, rbuf_lo};
    end
  end

endmodule

// File: tb/tb_sdram_word_arbiter.sv
// Scoreboard bench for sdram_word_arbiter.
// Expected commands/acks queued at issue, checked by a monitor.
module tb_sdram_word_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [20:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] rdata;
  logic        busy;
  logic [21:0] az_addr;
  logic [1:0]  az_be_n;
  logic        az_cs;
  logic [15:0] az_data;
  logic        az_rd_n, az_wr_n;
  logic [15:0] za_data;
  logic        za_valid;
  logic        za_waitrequest;

  sdram_word_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .p0_req         (p0_req),
    .p0_we          (p0_we),
    .p0_addr        (p0_addr),
    .p0_wdata       (p0_wdata),
    .p1_req         (p1_req),
    .p1_we          (p1_we),
    .p1_addr        (p1_addr),
    .p1_wdata       (p1_wdata),
    .p0_ack         (p0_ack),
    .p1_ack         (p1_ack),
    .rdata          (rdata),
    .busy           (busy),
    .az_addr        (az_addr),
    .az_be_n        (az_be_n),
    .az_cs          (az_cs),
    .az_data        (az_data),
    .az_rd_n        (az_rd_n),
    .az_wr_n        (az_wr_n),
    .za_data        (za_data),
    .za_valid       (za_valid),
    .za_waitrequest (za_waitrequest)
  );

  typedef struct {
    logic [21:0] addr;
    logic [15:0] data;
    logic        we;
  } cmd_t;

  typedef struct {
    logic        port;
    logic        rd;
    logic [31:0] rdata;
    int          cyc;
  } ack_t;

  cmd_t        cmd_q[$];
  ack_t        ack_q[$];
  logic [15:0] rd_hw[$];
  int          pend_due[$];
  logic [15:0] pend_dat[$];
  int          rd_lat;
  int          cyc;
  int          cmd_seen;
  int          chk;
  int          npass;
  bit          acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] exp);
    chk++;
    if (act === exp)
      npass++;
    else
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic fail_now(string nm);
    chk++;
    $display("FAIL %s: unexpected or missing event", nm);
  endtask

  // Controller model: returns queued halfwords rd_lat cycles
  // after each accepted read command.
  initial begin
    za_valid = 1'b0;
    za_data  = 16'd0;
    forever begin
      @(posedge clk);
      acc = az_cs & ~az_rd_n & ~za_waitrequest & ~reset;
      #1;
      za_valid = 1'b0;
      if (reset) begin
        pend_due.delete();
        pend_dat.delete();
      end else begin
        if (acc && rd_hw.size() > 0) begin
          pend_due.push_back(cyc + rd_lat);
          pend_dat.push_back(rd_hw.pop_front());
        end
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          za_valid = 1'b1;
          za_data  = pend_dat.pop_front();
          void'(pend_due.pop_front());
        end
      end
    end
  end

  // Monitor: compares accepted commands and acks to the scoreboard.
  initial begin
    cmd_t e;
    ack_t a;
    cmd_seen = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (az_cs && !za_waitrequest) begin
          cmd_seen++;
          if (cmd_q.size() == 0) begin
            fail_now("cmd_unexpected");
          end else begin
            e = cmd_q.pop_front();
            check("cmd", 64'({az_addr, az_data, az_rd_n, az_wr_n}),
                  64'({e.addr, e.data, e.we, ~e.we}));
          end
        end
        if (p0_ack && p1_ack)
          fail_now("ack_both");
        if (p0_ack || p1_ack) begin
          if (ack_q.size() == 0) begin
            fail_now("ack_unexpected");
          end else begin
            a = ack_q.pop_front();
            check("ack_port", 64'(p1_ack), 64'(a.port));
            if (a.cyc >= 0)
              check("ack_latency", 64'(cyc), 64'(a.cyc));
            if (a.rd)
              check("rdata", 64'(rdata), 64'(a.rdata));
          end
        end
      end
    end
  end

  task automatic push_exp(bit port, bit we, logic [20:0] addr,
                          logic [31:0] wd, logic [31:0] rexp,
                          int ecyc);
    cmd_t c;
    ack_t a;
    c.addr = {addr, 1'b0};
    c.data = wd[15:0];
    c.we   = we;
    cmd_q.push_back(c);
    c.addr = {addr, 1'b1};
    c.data = wd[31:16];
    cmd_q.push_back(c);
    a.port  = port;
    a.rd    = ~we;
    a.rdata = rexp;
    a.cyc   = ecyc;
    ack_q.push_back(a);
  endtask

  task automatic start(bit port, bit we, logic [20:0] addr,
                       logic [31:0] wd, logic [15:0] lo,
                       logic [15:0] hi, logic [31:0] rexp,
                       int lat);
    @(posedge clk);
    #1;
    if (!we) begin
      rd_hw.push_back(lo);
      rd_hw.push_back(hi);
    end
    push_exp(port, we, addr, wd, rexp, (lat < 0) ? -1 : cyc + lat);
    if (port) begin
      p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
    end
  endtask

  task automatic wait_acks(int n);
    int got = 0;
    int t = 0;
    while (got < n && t < 300) begin
      @(negedge clk);
      t++;
      if (p0_ack || p1_ack) begin
        got++;
        if (got == n) begin
          p0_req = 1'b0;
          p1_req = 1'b0;
        end
      end
    end
    if (got < n) begin
      fail_now("ack_timeout");
      p0_req = 1'b0;
      p1_req = 1'b0;
    end
  endtask

  task automatic check_reset_outs(string nm);
    check(nm, 64'({az_cs, az_rd_n, az_wr_n, az_be_n, az_addr,
                   az_data, p0_ack, p1_ack, busy}),
          64'({1'b0, 1'b1, 1'b1, 2'b00, 22'h0, 16'h0, 3'b000}));
    check({nm, "_rdata"}, 64'(rdata), 64'h0);
  endtask

  initial begin
    int base;
    int t;
    chk = 0;
    npass = 0;
    rd_lat = 0;
    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    za_waitrequest = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // p1 write, no stall
    start(1, 1, 21'h00010, 32'hDEADBEEF, 0, 0, 0, 3);
    wait_acks(1);

    // p0 read, beats two cycles after each command
    rd_lat = 2;
    start(0, 0, 21'h00004, 0, 16'h5678, 16'h1234,
          32'h12345678, 6);
    wait_acks(1);

    // stray beat while idle is ignored
    @(posedge clk);
    #1;
    pend_due.push_back(cyc);
    pend_dat.push_back(16'hFFFF);
    repeat (3) @(negedge clk);
    check("stray_busy", 64'(busy), 64'h0);
    check("stray_rdata", 64'(rdata), 64'h12345678);

    // p0 write with 4-cycle stall on the low command
    za_waitrequest = 1'b1;
    base = cmd_seen;
    start(0, 1, 21'h1ABCD, 32'hCAFEF00D, 0, 0, 0, 7);
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      check("stall_hold", 64'({az_cs, az_wr_n, az_rd_n, az_addr,
                               az_data}),
            64'({1'b1, 1'b0, 1'b1, 22'h3579A, 16'hF00D}));
      @(posedge clk);
    end
    #1 za_waitrequest = 1'b0;
    wait_acks(1);
    check("stall_cmds", 64'(cmd_seen - base), 64'd2);

    // p1 read, first beat while the high command is accepted
    rd_lat = 0;
    start(1, 0, 21'h155555, 0, 16'hAAAA, 16'h5555,
          32'h5555AAAA, 4);
    wait_acks(1);

    // p1 write whose req drops after grant still completes
    start(1, 1, 21'h00007, 32'h01020304, 0, 0, 0, 3);
    @(posedge clk);
    #1 p1_req = 1'b0;
    wait_acks(1);

    // contention over four transactions
    @(posedge clk);
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    push_exp(0, 1, 21'h100, 32'h11112222, 0, -1);
    push_exp(1, 1, 21'h200, 32'h33334444, 0, -1);
    push_exp(0, 1, 21'h100, 32'h11112222, 0, -1);
    push_exp(1, 1, 21'h200, 32'h33334444, 0, -1);
`else
    repeat (4) push_exp(0, 1, 21'h100, 32'h11112222, 0, -1);
`endif
    p0_we = 1; p0_addr = 21'h100; p0_wdata = 32'h11112222;
    p1_we = 1; p1_addr = 21'h200; p1_wdata = 32'h33334444;
    p0_req = 1'b1;
    p1_req = 1'b1;
    wait_acks(4);

    // reset during WAIT_RD abandons the read
    rd_lat = 6;
    base = cmd_seen;
    start(0, 0, 21'h00020, 0, 16'h1111, 16'h2222,
          32'h22221111, -1);
    t = 0;
    while (cmd_seen < base + 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (cmd_seen < base + 2)
      fail_now("rst_cmd_timeout");
    @(posedge clk);
    #1;
    reset = 1'b1;
    p0_req = 1'b0;
    void'(ack_q.pop_back());
    @(negedge clk);
    check_reset_outs("mid_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'h0);

    // read after reset completes normally
    rd_lat = 1;
    start(0, 0, 21'h00021, 0, 16'h0BAD, 16'hF00D,
          32'hF00D0BAD, 5);
    wait_acks(1);

    repeat (3) @(negedge clk);
    check("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check("ack_q_empty", 64'(ack_q.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, chk);
    $finish;
  end

endmodule

// File: doc/sdram_word_arbiter.md
SDRAM_WORD_ARBITER -- requirements
Module: sdram_word_arbiter

Interface
REQ-001 clk  in  1  system clock; all state changes on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 p0_req, p1_req  in  1 each  transaction request from port 0 (program loader) and port 1 (CPU); held high until that port's ack.
REQ-004 p0_we, p1_we  in  1 each  1 = write, 0 = read; stable while req high.
REQ-005 p0_addr, p1_addr  in  21 each  32-bit word index; stable while req high.
REQ-006 p0_wdata, p1_wdata  in  32 each  write data; stable while req high.
REQ-007 p0_ack, p1_ack  out  1 each  one-cycle completion pulse.
REQ-008 rdata  out  32  read result; valid in the ack cycle and held until the next read completes.
REQ-009 busy  out  1  high whenever the FSM is not in IDLE.
REQ-010 az_addr  out  22  halfword address to the SDRAM controller.
REQ-011 az_be_n  out  2  byte enables, active low; always 2'b00.
REQ-012 az_cs  out  1  high while a command is presented.
REQ-013 az_data  out  16  write halfword.
REQ-014 az_rd_n, az_wr_n  out  1 each  active-low read and write strobes.
REQ-015 za_data  in  16  read halfword from the controller.
REQ-016 za_valid  in  1  za_data valid this cycle.
REQ-017 za_waitrequest  in  1  controller stall; the presented command is not accepted while high.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE_LO, ISSUE_HI, WAIT_RD and DONE.
REQ-019 IDLE: when any req is high, grant one port per REQ-031, latch its we, addr and wdata, then go to ISSUE_LO.
REQ-020 ISSUE_LO: drive az_cs=1, az_addr={addr,1'b0}, az_data=wdata[15:0], and strobe az_wr_n=0 for a write or az_rd_n=0 for a read; hold all of these while za_waitrequest=1; go to ISSUE_HI in the first cycle in which za_waitrequest=0.
REQ-021 ISSUE_HI: same as ISSUE_LO with az_addr={addr,1'b1} and az_data=wdata[31:16]; on acceptance, a write goes to DONE, and a read goes to WAIT_RD, or straight to DONE if both beats have already been captured.
REQ-022 Outside ISSUE_LO and ISSUE_HI: az_cs=0, az_rd_n=1, az_wr_n=1.
REQ-023 Read beats: a 2-bit beat counter SHALL capture za_valid beats in any state from ISSUE_LO acceptance onward; beat 0 goes to rdata[15:0], beat 1 to rdata[31:16].
REQ-024 WAIT_RD: after the second beat is captured, go to DONE.
REQ-025 za_valid outside an active read, or beyond two beats, SHALL be ignored with no state change.
REQ-026 DONE: pulse the granted port's ack for exactly one cycle, then return to IDLE; IDLE re-arbitrates in the cycle after DONE.
REQ-027 Minimum write latency with no stall: ack 3 cycles after the grant edge.
REQ-028 Minimum read latency: ack 1 cycle after the second valid beat.
REQ-029 Requests arriving while busy SHALL be held off until IDLE; no request is lost while its req stays high.
REQ-030 Dropping req mid-transaction SHALL NOT abort it; ack still pulses.
REQ-031 Arbitration: see REQ-034 and REQ-035.

Reset
REQ-032 While reset=1: FSM=IDLE; az_cs=0, az_rd_n=1, az_wr_n=1, az_be_n=2'b00; az_addr, az_data, rdata=0; p0_ack=p1_ack=0; busy=0; beat counter=0; last_grant=1.
REQ-033 Reset asserted mid-transaction SHALL abandon it with no ack; after release the block accepts new requests normally.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the port not granted last (last_grant register, updated on every grant).
REQ-035 Macro ARB_ROUND_ROBIN_EN undefined: port 0 always wins simultaneous requests; the last_grant register is absent.

Verification
REQ-036 p1 write addr=0x00010, wdata=0xDEADBEEF, no stall -> halfword commands at az_addr 0x00020 (data 0xBEEF) then 0x00021 (data 0xDEAD); p1_ack 3 cycles after grant.
REQ-037 p0 read addr=0x00004; controller returns 0x5678 then 0x1234 -> rdata=0x12345678 with p0_ack.
REQ-038 za_waitrequest held high 4 cycles during ISSUE_LO -> az_addr, az_cs and strobes held stable for those 4 cycles; exactly two commands accepted.
REQ-039 p0_req and p1_req both held high for 4 transactions -> with ARB_ROUND_ROBIN_EN, grant order 0,1,0,1; without it, 0,0,0,0.
REQ-040 Reset pulsed during WAIT_RD -> no ack, all outputs at reset values; next read completes correctly.
REQ-041 Read whose first za_valid arrives in the same cycle ISSUE_HI is accepted -> beat captured, rdata correct.
